// File: rtl/sample_counter_pkg.sv
// Shared state encodings and default sizing for the sample stamp counter.
package sample_counter_pkg;

    localparam int unsigned CNT_W_DEF  = 64;
    localparam int unsigned NUM_CH_DEF = 4;
    localparam int unsigned STATE_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'b00,
        ST_COUNT   = 2'b01,
        ST_PAUSE   = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_e;

    // Snapshots are only accepted once counting has been started.
    function automatic logic snap_enabled(input state_e s);
        return (s == ST_COUNT) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/sample_snap_slot.sv
// One snapshot channel: capture, valid/ready handshake and sticky drop flag.
module sample_snap_slot
    import sample_counter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             axis_aclk,
    input  logic             axis_aresetn,
    input  logic             i_clear,
    input  logic             i_cap,
    input  logic [CNT_W-1:0] i_cap_val,
    input  logic             i_rdy,
    output logic [CNT_W-1:0] o_data,
    output logic             o_vld,
    output logic             o_ovf
);

    logic [CNT_W-1:0] data_q, data_d;
    logic             vld_q, vld_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        ovf_d  = ovf_q;
        if (i_clear) begin
            vld_d = 1'b0;
            ovf_d = 1'b0;
        end else if (i_cap) begin
            // A pending, unaccepted snapshot wins; the new one is dropped.
            if (vld_q && !i_rdy) begin
                ovf_d = 1'b1;
            end else begin
                data_d = i_cap_val;
                vld_d  = 1'b1;
            end
        end else if (vld_q && i_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            data_q <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            ovf_q  <= ovf_d;
        end
    end

    assign o_data = data_q;
    assign o_vld  = vld_q;
    assign o_ovf  = ovf_q;

endmodule

// File: rtl/sample_stamp_counter.sv
// Start/stop sample counter with per-channel timestamp snapshots.
module sample_stamp_counter
    import sample_counter_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned NUM_CH = NUM_CH_DEF
) (
    input  logic                    axis_aclk,
    input  logic                    axis_aresetn,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic                    i_clear,
    input  logic                    i_vld,
    output logic                    o_vld,
    output logic [CNT_W-1:0]        o_count,
    output logic                    o_wrap,
    output logic [1:0]              o_state,
    input  logic [NUM_CH-1:0]       i_epoch,
    output logic [NUM_CH*CNT_W-1:0] o_snap_data,
    output logic [NUM_CH-1:0]       o_snap_vld,
    input  logic [NUM_CH-1:0]       i_snap_rdy,
    output logic [NUM_CH-1:0]       o_snap_ovf
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             vld_q, vld_d;
    logic             wrap_q, wrap_d;
    logic             counted;
    logic             cap_active;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        vld_d      = 1'b0;
        wrap_d     = 1'b0;
        counted    = 1'b0;
        cap_active = 1'b0;
        if (i_clear) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            cap_active = snap_enabled(state_q);
            case (state_q)
                ST_IDLE:  if (i_start) state_d = ST_COUNT;
                ST_COUNT: begin
                    counted = i_vld;
                    if (i_stop) state_d = ST_PAUSE;
                end
                ST_PAUSE: if (i_start && !i_stop) state_d = ST_COUNT;
                default:  state_d = ST_IDLE;
            endcase
            if (counted) begin
                count_d = count_q + CNT_W'(1);
                vld_d   = 1'b1;
                wrap_d  = (count_q == {CNT_W{1'b1}});
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            vld_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_state = 2'(state_q);
    assign o_count = count_q;
    assign o_vld   = vld_q;
    assign o_wrap  = wrap_q;

    // Every channel samples the pre-increment registered count.
    for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_slot
        sample_snap_slot #(
            .CNT_W (CNT_W)
        ) u_slot (
            .axis_aclk    (axis_aclk),
            .axis_aresetn (axis_aresetn),
            .i_clear      (i_clear),
            .i_cap        (cap_active & i_epoch[k]),
            .i_cap_val    (count_q),
            .i_rdy        (i_snap_rdy[k]),
            .o_data       (o_snap_data[k*CNT_W +: CNT_W]),
            .o_vld        (o_snap_vld[k]),
            .o_ovf        (o_snap_ovf[k])
        );
    end

endmodule

// File: tb/tb_sample_stamp_counter.sv
// Directed, table-driven bench for sample_stamp_counter (CNT_W=16, NUM_CH=4).
module tb_sample_stamp_counter;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned NUM_CH = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    i_start, i_stop, i_clear, i_vld;
    logic                    o_vld, o_wrap;
    logic [CNT_W-1:0]        o_count;
    logic [1:0]              o_state;
    logic [NUM_CH-1:0]       i_epoch, o_snap_vld, i_snap_rdy, o_snap_ovf;
    logic [NUM_CH*CNT_W-1:0] o_snap_data;

    int checks   = 0;
    int failures = 0;
    int wraps    = 0;

    always #5 clk = ~clk;

    sample_stamp_counter #(
        .CNT_W  (CNT_W),
        .NUM_CH (NUM_CH)
    ) dut (
        .axis_aclk    (clk),
        .axis_aresetn (rst_n),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_clear      (i_clear),
        .i_vld        (i_vld),
        .o_vld        (o_vld),
        .o_count      (o_count),
        .o_wrap       (o_wrap),
        .o_state      (o_state),
        .i_epoch      (i_epoch),
        .o_snap_data  (o_snap_data),
        .o_snap_vld   (o_snap_vld),
        .i_snap_rdy   (i_snap_rdy),
        .o_snap_ovf   (o_snap_ovf)
    );

    typedef struct packed {
        logic        start;
        logic        stop;
        logic        clr;
        logic        vld;
        logic [1:0]  st;
        logic [15:0] cnt;
        logic        ov;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (o_wrap) wraps++;
    endtask

    task automatic run_vld(input int n);
        i_vld = 1'b1;
        repeat (n) tick();
        i_vld = 1'b0;
    endtask

    task automatic pulse_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    function automatic logic [CNT_W-1:0] snap_of(input int k);
        return o_snap_data[k*CNT_W +: CNT_W];
    endfunction

    initial begin
        rst_n = 1'b0;
        {i_start, i_stop, i_clear, i_vld} = '0;
        i_epoch = '0;
        i_snap_rdy = '0;

        // State sequence from IDLE/0: {start,stop,clr,vld} -> {state,count,o_vld}
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 16'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 16'd1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 16'd2, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 16'd2, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 16'd3, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 16'd3, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 16'd3, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 16'd3, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 16'd4, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 16'd4, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16'd0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 16'd0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 16'd0, 1'b0};

        #12;
        chk("rst_state", 64'(o_state), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_vld", 64'(o_vld), 64'd0);
        chk("rst_wrap", 64'(o_wrap), 64'd0);
        chk("rst_snap_vld", 64'(o_snap_vld), 64'd0);
        chk("rst_snap_ovf", 64'(o_snap_ovf), 64'd0);
        chk("rst_snap_data", 64'(o_snap_data), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_state", 64'(o_state), 64'd0);

        for (int i = 0; i < 14; i++) begin
            {i_start, i_stop, i_clear, i_vld} = {vecs[i].start, vecs[i].stop, vecs[i].clr, vecs[i].vld};
            tick();
            chk($sformatf("vec%0d_state", i), 64'(o_state), 64'(vecs[i].st));
            chk($sformatf("vec%0d_count", i), 64'(o_count), 64'(vecs[i].cnt));
            chk($sformatf("vec%0d_vld", i), 64'(o_vld), 64'(vecs[i].ov));
        end
        {i_start, i_stop, i_clear, i_vld} = '0;

        // Ten counted samples
        pulse_start();
        chk("run_state", 64'(o_state), 64'd1);
        i_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("run_ovld%0d", i), 64'(o_vld), 64'd1);
        end
        i_vld = 1'b0;
        chk("run_count10", 64'(o_count), 64'd10);
        tick();
        chk("run_ovld_drop", 64'(o_vld), 64'd0);
        chk("run_state_end", 64'(o_state), 64'd1);

        // Pause holds count, resume continues
        pulse_clear();
        pulse_start();
        run_vld(5);
        chk("pause_count5", 64'(o_count), 64'd5);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk("pause_state", 64'(o_state), 64'd2);
        i_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("pause_ovld%0d", i), 64'(o_vld), 64'd0);
        end
        i_vld = 1'b0;
        chk("pause_hold", 64'(o_count), 64'd5);
        pulse_start();
        chk("resume_state", 64'(o_state), 64'd1);
        run_vld(1);
        chk("resume_count6", 64'(o_count), 64'd6);

        // Snapshot capture and overflow on channel 2
        pulse_clear();
        pulse_start();
        run_vld(42);
        chk("snap_pre42", 64'(o_count), 64'd42);
        i_epoch = 4'b0100;
        i_vld = 1'b1;
        tick();
        i_epoch = '0;
        i_vld = 1'b0;
        chk("snap2_data42", 64'(snap_of(2)), 64'd42);
        chk("snap2_vld", 64'(o_snap_vld), 64'b0100);
        chk("snap2_ovf0", 64'(o_snap_ovf), 64'd0);
        chk("snap_count43", 64'(o_count), 64'd43);
        run_vld(7);
        chk("snap_count50", 64'(o_count), 64'd50);
        i_epoch = 4'b0100;
        tick();
        i_epoch = '0;
        chk("ovf2_data_kept", 64'(snap_of(2)), 64'd42);
        chk("ovf2_vld", 64'(o_snap_vld), 64'b0100);
        chk("ovf2_flag", 64'(o_snap_ovf), 64'b0100);
        i_snap_rdy = 4'b0100;
        tick();
        i_snap_rdy = '0;
        chk("acc2_vld_clr", 64'(o_snap_vld), 64'd0);
        chk("acc2_ovf_sticky", 64'(o_snap_ovf), 64'b0100);

        // Simultaneous epochs, then epoch coincident with handshake on ch1
        i_epoch = 4'b1011;
        i_vld = 1'b1;
        tick();
        chk("multi_d0", 64'(snap_of(0)), 64'd50);
        chk("multi_d1", 64'(snap_of(1)), 64'd50);
        chk("multi_d3", 64'(snap_of(3)), 64'd50);
        chk("multi_vld", 64'(o_snap_vld), 64'b1011);
        i_epoch = 4'b0010;
        i_snap_rdy = 4'b0010;
        tick();
        i_epoch = '0;
        i_snap_rdy = '0;
        i_vld = 1'b0;
        chk("coinc_d1", 64'(snap_of(1)), 64'd51);
        chk("coinc_vld", 64'(o_snap_vld), 64'b1011);
        chk("coinc_ovf", 64'(o_snap_ovf), 64'b0100);
        chk("coinc_d0_hold", 64'(snap_of(0)), 64'd50);
        i_snap_rdy = 4'b1111;
        tick();
        i_snap_rdy = '0;
        chk("drain_vld", 64'(o_snap_vld), 64'd0);

        // Clear resets flags; epochs ignored in IDLE
        pulse_clear();
        chk("clr_state", 64'(o_state), 64'd0);
        chk("clr_count", 64'(o_count), 64'd0);
        chk("clr_ovf", 64'(o_snap_ovf), 64'd0);
        i_epoch = 4'b1111;
        tick();
        i_epoch = '0;
        chk("idle_epoch_ignored", 64'(o_snap_vld), 64'd0);

        // Asynchronous reset mid-count
        pulse_start();
        run_vld(1000);
        chk("pre_rst_count1000", 64'(o_count), 64'd1000);
        i_epoch = 4'b0001;
        i_vld = 1'b1;
        tick();
        i_epoch = '0;
        chk("pre_rst_count1001", 64'(o_count), 64'd1001);
        chk("pre_rst_snap0", 64'(snap_of(0)), 64'd1000);
        #2 rst_n = 1'b0;
        #1;
        chk("async_count", 64'(o_count), 64'd0);
        chk("async_state", 64'(o_state), 64'd0);
        chk("async_ovld", 64'(o_vld), 64'd0);
        chk("async_wrap", 64'(o_wrap), 64'd0);
        chk("async_snap_vld", 64'(o_snap_vld), 64'd0);
        chk("async_snap_ovf", 64'(o_snap_ovf), 64'd0);
        chk("async_snap_data", 64'(o_snap_data), 64'd0);
        tick();
        rst_n = 1'b1;
        i_vld = 1'b0;
        tick();
        chk("rel_state", 64'(o_state), 64'd0);
        chk("rel_count", 64'(o_count), 64'd0);

        // Clear from PAUSE
        pulse_start();
        run_vld(3);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk("p_clr_pre_state", 64'(o_state), 64'd2);
        chk("p_clr_pre_count", 64'(o_count), 64'd3);
        pulse_clear();
        chk("p_clr_state", 64'(o_state), 64'd0);
        chk("p_clr_count", 64'(o_count), 64'd0);

        // Wrap at 16 bits
        pulse_start();
        wraps = 0;
        run_vld(65535);
        chk("wrap_pre_count", 64'(o_count), 64'd65535);
        chk("wrap_none_yet", 64'(wraps), 64'd0);
        run_vld(1);
        chk("wrap_count0", 64'(o_count), 64'd0);
        chk("wrap_pulse", 64'(o_wrap), 64'd1);
        tick();
        chk("wrap_pulse_end", 64'(o_wrap), 64'd0);
        chk("wrap_once", 64'(wraps), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sample_stamp_counter.md
SAMPLE_STAMP_COUNTER -- requirements
Module: sample_stamp_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 64, sample-counter width (16..64).
REQ-002 SHALL have parameter NUM_CH, default 4, number of snapshot channels (1..16).
REQ-003 SHALL have port axis_aclk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port axis_aresetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_start, input, 1, start/resume counting.
REQ-006 SHALL have port i_stop, input, 1, pause counting.
REQ-007 SHALL have port i_clear, input, 1, synchronous return to IDLE and counter clear.
REQ-008 SHALL have port i_vld, input, 1, one input sample present this cycle.
REQ-009 SHALL have port o_vld, output, 1, registered pulse per counted sample.
REQ-010 SHALL have port o_count, output, CNT_W, running sample count.
REQ-011 SHALL have port o_wrap, output, 1, one-cycle pulse on counter wrap to zero.
REQ-012 SHALL have port o_state, output, 2, current FSM state.
REQ-013 SHALL have port i_epoch, input, NUM_CH, per-channel snapshot request strobes.
REQ-014 SHALL have port o_snap_data, output, NUM_CH*CNT_W, captured counts; channel k in bits [k*CNT_W +: CNT_W].
REQ-015 SHALL have port o_snap_vld, output, NUM_CH, per-channel snapshot valid.
REQ-016 SHALL have port i_snap_rdy, input, NUM_CH, per-channel snapshot ready.
REQ-017 SHALL have port o_snap_ovf, output, NUM_CH, sticky per-channel snapshot-drop flag.

Function
REQ-018 SHALL implement states IDLE=2'b00, COUNT=2'b01, PAUSE=2'b10; 2'b11 SHALL go to IDLE next cycle.
REQ-019 SHALL transition IDLE->COUNT on i_start; COUNT->PAUSE on i_stop; PAUSE->COUNT on i_start without i_stop.
REQ-020 SHALL give i_clear highest priority: any state -> IDLE; o_count, o_snap_vld, o_snap_ovf to 0 next cycle.
REQ-021 SHALL, in COUNT with i_start and i_stop both high, go to PAUSE; in PAUSE with both high, stay in PAUSE.
REQ-022 SHALL increment o_count by 1 one cycle after a cycle with i_vld=1 and state COUNT; otherwise hold.
REQ-023 SHALL drive o_vld=1 one cycle after each counted sample, else 0; samples in IDLE/PAUSE are neither counted nor flagged.
REQ-024 SHALL wrap o_count from 2^CNT_W-1 to 0 (modulo), pulsing o_wrap in the same cycle o_count becomes 0.
REQ-025 SHALL, on i_epoch[k]=1 in COUNT or PAUSE, capture the current registered o_count (pre-increment) into channel k next cycle and set o_snap_vld[k].
REQ-026 SHALL ignore i_epoch in IDLE.
REQ-027 SHALL clear o_snap_vld[k] after a cycle with o_snap_vld[k] and i_snap_rdy[k] both high; o_snap_data[k] SHALL hold while valid and not accepted.
REQ-028 SHALL, on i_epoch[k] while o_snap_vld[k]=1 and i_snap_rdy[k]=0, drop the new capture, keep old data, set o_snap_ovf[k].
REQ-029 SHALL, on i_epoch[k] in the same cycle as the channel-k handshake, load the new capture and keep o_snap_vld[k]=1 with no overflow.
REQ-030 SHALL treat channels independently; simultaneous epochs on several channels capture the same value.

Reset
REQ-031 SHALL, while axis_aresetn=0, force state IDLE and all outputs (o_vld, o_count, o_wrap, o_snap_data, o_snap_vld, o_snap_ovf) to 0 asynchronously.
REQ-032 SHALL resume at IDLE on the first edge after release, regardless of state at assertion.

Structure
REQ-033 SHALL place state encodings and default CNT_W/NUM_CH values in a shared package, sample_counter_pkg.
REQ-034 SHALL implement one channel's capture/handshake/overflow logic as sub-module sample_snap_slot, instantiated NUM_CH times.

Verification
REQ-035 SHALL test: reset, i_start, 10 cycles i_vld=1 -> o_count=10, o_vld high 10 cycles, o_state=01.
REQ-036 SHALL test: CNT_W=16, preload by counting to 65535, one more i_vld -> o_count=0, one o_wrap pulse.
REQ-037 SHALL test: i_stop at count 5, 4 i_vld -> o_count stays 5; i_start -> counting resumes at 6.
REQ-038 SHALL test: i_epoch[2] at o_count=42, i_snap_rdy[2]=0, second epoch at 50 -> data=42, o_snap_ovf[2]=1; rdy -> vld clears.
REQ-039 SHALL test: epoch coincident with handshake -> new value loaded, o_snap_vld stays 1, ovf stays 0.
REQ-040 SHALL test: axis_aresetn low mid-count at 1000 -> all outputs 0 immediately; i_clear from PAUSE -> IDLE, count 0.
